// File: rtl/cover_toggle_collector_pkg.sv
// Shared types and constants for the cover collector.
// FSM state encoding, index width and counting modes.
package cover_pkg;

  localparam int COVER_INDEX_W = 64;
  localparam int MODE_LEVEL    = 0;
  localparam int MODE_TOGGLE   = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HOLD,
    ST_DONE
  } cover_state_e;

endpackage

// File: rtl/cover_sat_counter.sv
// Per-point saturating hit counter.
// clr beats rd_clr; an inc during rd_clr leaves 1.
module cover_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             rd_clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // next count: clear, read-clear, or saturating increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (rd_clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cover_toggle_collector.sv
// Cover-point hit collector with a drain scan.
// Counts level or toggle hits, drains nonzero points.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int WIDTH       = 36,
  parameter int CNT_W       = 8,
  parameter int MODE        = 0,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 10906
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         valid,
  input  logic                     clear,
  input  logic                     dump_req,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COVER_INDEX_W-1:0] out_index,
  output logic [CNT_W-1:0]         out_count,
  output logic                     dump_done
);

  localparam int PTR_W =
    (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(WIDTH - 1);

  cover_state_e state_d;
  cover_state_e state_q;

  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_q;

  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] prev_q;
  logic             seen_d;
  logic             seen_q;

  logic [COVER_INDEX_W-1:0] out_index_d;
  logic [COVER_INDEX_W-1:0] out_index_q;
  logic [CNT_W-1:0]         out_count_d;
  logic [CNT_W-1:0]         out_count_q;

  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] rd_clr;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [CNT_W-1:0] cur_cnt;

  // hit vector: level or toggle against last sample
  always_comb begin
    if (MODE == MODE_TOGGLE) begin
      hit = (valid ^ prev_q)
          & {WIDTH{enable & seen_q}};
    end else begin
      hit = valid & {WIDTH{enable}};
    end
  end

  // previous sample tracks valid every cycle
  always_comb begin
    prev_d = valid;
    seen_d = 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
    cover_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (hit[i]),
      .clr     (clear),
      .rd_clr  (rd_clr[i]),
      .count   (cnt[i])
    );
  end

  assign cur_cnt = cnt[ptr_q];

  // drain FSM: skip empty points, hold nonzero ones
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_index_d = out_index_q;
    out_count_d = out_count_q;
    rd_clr      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cur_cnt == '0) begin
          if (ptr_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end else begin
          out_index_d = COVER_INDEX_W'(COVER_INDEX)
                      + COVER_INDEX_W'(ptr_q);
          out_count_d = cur_cnt;
          rd_clr[ptr_q] = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (ptr_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, pointer, sample and drain registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      prev_q      <= '0;
      seen_q      <= 1'b0;
      out_index_q <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      prev_q      <= prev_d;
      seen_q      <= seen_d;
      out_index_q <= out_index_d;
      out_count_q <= out_count_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign dump_done = (state_q == ST_DONE);
  assign out_index = out_index_q;
  assign out_count = out_count_q;

endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 Parameter WIDTH, default 36, number of monitored cover points (1..256).
REQ-002 Parameter CNT_W, default 8, per-point saturating hit-counter width (1..16).
REQ-003 Parameter MODE, default 0: 0 = level hit (valid[i] high counts), 1 = toggle hit (valid[i] changed since previous cycle counts).
REQ-004 Parameter COVER_INDEX, default 0, global index of bit 0; parameter COVER_TOTAL, default 10906, global cover-point count (informational, exported unchanged).
REQ-005 Port clock  in  1  sole clock, all state on rising edge.
REQ-006 Port reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port enable  in  1  event counting gate.
REQ-008 Port valid  in  WIDTH  monitored cover signals.
REQ-009 Port clear  in  1  synchronous zero of all counters.
REQ-010 Port dump_req  in  1  start one drain scan.
REQ-011 Port busy  out  1  scan in progress, high from the cycle after an accepted dump_req through the DONE cycle.
REQ-012 Ports out_valid  out  1 / out_ready  in  1: drain handshake; a beat transfers when both are high.
REQ-013 Port out_index  out  64  COVER_INDEX + i of the presented point.
REQ-014 Port out_count  out  CNT_W  hit count of the presented point.
REQ-015 Port dump_done  out  1  one-cycle pulse marking scan completion.

Function
REQ-016 Event on bit i: MODE 0 -> enable && valid[i]; MODE 1 -> enable && prev_seen && (valid[i] != prev[i]).
REQ-017 prev loads valid every cycle regardless of enable; prev_seen sets on the first cycle after reset, so no toggle is counted on the first sample.
REQ-018 Counter i increments by 1 per event and saturates at 2^CNT_W-1; no wrap-around.
REQ-019 FSM states IDLE, SCAN, HOLD, DONE; dump_req is accepted only in IDLE and ignored otherwise.
REQ-020 IDLE + dump_req -> SCAN with ptr=0 next cycle.
REQ-021 In SCAN: cnt[ptr]==0 -> ptr+1 (SCAN), or DONE when ptr==WIDTH-1; cnt[ptr]!=0 -> out_index/out_count captured, cnt[ptr] read-cleared, go to HOLD.
REQ-022 In HOLD: out_valid=1; out_index/out_count stay stable until handshake; on handshake ptr+1 to SCAN, or DONE when ptr==WIDTH-1.
REQ-023 DONE lasts exactly one cycle with dump_done=1, then IDLE.
REQ-024 Latency: dump_req at cycle t with cnt[0]!=0 gives out_valid at t+2; with no backpressure a scan takes at most 2*WIDTH+2 cycles.
REQ-025 Event on the bit being read-cleared in the same cycle leaves that counter at 1; the event is not lost.
REQ-026 clear has priority over events and read-clear, leaving all counters 0; the scan continues, and a beat already in HOLD remains valid and unchanged.
REQ-027 Counting continues during a scan; points already passed are reported by the next dump.

Reset
REQ-028 reset_n low asynchronously forces: all counters 0, prev 0, prev_seen 0, ptr 0, state IDLE, out_valid 0, out_index 0, out_count 0, busy 0, dump_done 0.
REQ-029 Reset asserted mid-scan aborts the scan; no dump_done is produced.

Structure
REQ-030 Shared package cover_pkg holds the FSM state enum, COVER_INDEX_W=64, and MODE_LEVEL/MODE_TOGGLE constants.
REQ-031 One sub-module, cover_sat_counter (inc, clr, rd_clr, count), is instantiated WIDTH times; the FSM and drain register live in the top module.

Verification (WIDTH=36, CNT_W=4, COVER_INDEX=100 unless stated)
REQ-032 MODE 0, valid[3]=1 for 5 enabled cycles, then dump -> one beat index 103 count 5, then dump_done; an immediate second dump -> no beats, dump_done within 38 cycles.
REQ-033 valid[35]=1 for 20 cycles, dump -> beat index 135 count 15 (saturated).
REQ-034 MODE 1, after reset valid[0]=1,0,1,0 on successive cycles, dump -> index 100 count 3.
REQ-035 Bits 1 and 2 hit once each, out_ready low 10 cycles -> index 101 count 1 held stable throughout; raise out_ready -> index 102 count 1 on the next beat, then dump_done.
REQ-036 Event on bit 5 in the read-clear cycle -> first dump reports the prior count, second dump reports index 105 count 1.
REQ-037 clear and an event in the same cycle -> counter 0; reset_n low during HOLD -> out_valid and busy low immediately, and no dump_done.
